// File: rtl/cpu_sram_bridge.sv
// CPU-side front end for spi_sram_master: turns single-byte 6502 accesses into mem_* requests and stalls via cpu_rdy.
// Optional single-entry read cache enabled by defining CPU_SRAM_BRIDGE_RCACHE_EN.
module cpu_sram_bridge #(
  parameter logic [7:0] ADDR_HI = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic        cpu_ack,
  input  logic        mem_ready,
  output logic [23:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WLOW, WHIGH} state_t;

  state_t state;
  logic   hit;
  logic [7:0] hit_data;

`ifdef CPU_SRAM_BRIDGE_RCACHE_EN
  logic [15:0] tag_reg;
  logic [7:0]  data_reg;
  logic        valid_reg;
  logic        done;

  assign hit      = valid_reg && !cpu_we && (tag_reg == cpu_addr);
  assign hit_data = data_reg;
  assign done     = en && (state == WHIGH) && mem_ready;

  // Reads fill from the master; writes are written through with the CPU data.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg   <= 16'h0000;
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
    end else if (done) begin
      tag_reg   <= mem_addr[15:0];
      data_reg  <= mem_wr ? mem_wdata : mem_rdata;
      valid_reg <= 1'b1;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_addr  <= 24'h000000;
      mem_wr    <= 1'b0;
      mem_wdata <= 8'h00;
      cpu_rdy   <= 1'b1;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
    end else if (en) begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (hit) begin
              cpu_rdata <= hit_data;
              cpu_ack   <= 1'b1;
            end else begin
              mem_addr  <= {ADDR_HI, cpu_addr};
              mem_wr    <= cpu_we;
              mem_wdata <= cpu_wdata;
              mem_en    <= 1'b1;
              cpu_rdy   <= 1'b0;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_en <= 1'b0;
            state  <= WLOW;
          end
        end
        // The master drops mem_ready just after accepting, so skip one cycle before looking again.
        WLOW: state <= WHIGH;
        WHIGH: begin
          if (mem_ready) begin
            if (!mem_wr) cpu_rdata <= mem_rdata;
            cpu_rdy <= 1'b1;
            cpu_ack <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Directed bench for cpu_sram_bridge with a small behavioural SPI master model; ADDR_HI=8'h05.
// Cache checks are selected by CPU_SRAM_BRIDGE_RCACHE_EN, matching the DUT build.
module tb_cpu_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        cpu_ack;
  logic        mem_ready;
  logic [23:0] mem_addr;
  logic        mem_en;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  cpu_sram_bridge #(.ADDR_HI(8'h05)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy), .cpu_ack(cpu_ack),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Clock enable: constant 1, or alternating when en_toggle is set.
  logic en_toggle = 1'b0;
  always @(negedge clk) en = en_toggle ? ~en : 1'b1;

  // Master model: accepts when ready, then stays busy for busy_cycles en cycles.
  int         busy_cycles = 0;
  logic [7:0] resp_data = 8'h00;
  logic       block_ready = 1'b0;
  logic       model_ready;
  int         model_cnt;
  assign mem_ready = model_ready & ~block_ready;

  always @(posedge clk) begin
    if (rst) begin
      model_ready <= 1'b1;
      model_cnt   <= 0;
      mem_rdata   <= 8'h00;
    end else if (en) begin
      if (mem_ready && mem_en) begin
        model_ready <= 1'b0;
        model_cnt   <= busy_cycles;
        mem_rdata   <= resp_data;
      end else if (!model_ready) begin
        if (model_cnt <= 1) model_ready <= 1'b1;
        else model_cnt <= model_cnt - 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observations of the last access.
  logic [23:0] cap_maddr;
  logic        cap_wr;
  logic [7:0]  cap_wdata;
  bit          got, rdy_low, stable_ok;
  int          en_hi_cnt, lat;

  task automatic do_access(input logic we, input logic [15:0] a, input logic [7:0] d, input int hold);
    bit cap = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    block_ready = (hold > 0);
    got = 0; rdy_low = 0; stable_ok = 1; en_hi_cnt = 0; lat = 0;
    cap_maddr = '0; cap_wr = 0; cap_wdata = '0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (mem_en) begin
        en_hi_cnt++;
        if (!cap) begin
          cap = 1; cap_maddr = mem_addr; cap_wr = mem_wr; cap_wdata = mem_wdata;
        end else if (mem_addr !== cap_maddr || mem_wr !== cap_wr || mem_wdata !== cap_wdata) begin
          stable_ok = 0;
        end
        if (en_hi_cnt >= hold) block_ready = 1'b0;
      end
      if (!cpu_rdy) begin
        // Fields change while stalled; the bridge must ignore them.
        rdy_low = 1; cpu_addr = ~a; cpu_wdata = ~d; cpu_we = ~we;
      end
      if (cpu_ack) got = 1;
    end
    cpu_req = 1'b0;
    block_ready = 1'b0;
    chk("ack_seen", {31'd0, got}, 32'd1);
    repeat (2) @(negedge clk);
    chk("ack_single", {31'd0, cpu_ack}, 32'd0);
    chk("rdy_after", {31'd0, cpu_rdy}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  resp;
    int          busy;
    logic [23:0] exp_maddr;
    logic [7:0]  exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 2, 24'h051234, 8'hA5, 5};
    vecs[1] = '{1'b1, 16'h0010, 8'h3C, 8'h99, 1, 24'h050010, 8'hA5, 4};
    vecs[2] = '{1'b0, 16'hFFFF, 8'h81, 8'h5A, 0, 24'h05FFFF, 8'h5A, 4};
    vecs[3] = '{1'b0, 16'h0000, 8'h00, 8'h00, 5, 24'h050000, 8'h00, 8};
    vecs[4] = '{1'b1, 16'hFFFF, 8'hC3, 8'h42, 3, 24'h05FFFF, 8'h00, 6};
    vecs[5] = '{1'b0, 16'h0200, 8'h00, 8'h77, 1, 24'h050200, 8'h77, 4};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("rst_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("rst_maddr", {8'd0, mem_addr}, 32'd0);
    chk("rst_wr_wdata", {23'd0, mem_wr, mem_wdata}, 32'd0);

    // Table pass with en=1, then again with en toggling.
    for (int pass = 0; pass < 2; pass++) begin
      en_toggle = (pass == 1);
      for (int i = 0; i < 6; i++) begin
        busy_cycles = vecs[i].busy;
        resp_data   = vecs[i].resp;
        do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0);
        $display("[TB] pass %0d vec %0d we=%0b addr=%04h -> mem_addr=%06h rdata=%02h lat=%0d",
                 pass, i, vecs[i].we, vecs[i].addr, cap_maddr, cpu_rdata, lat);
        chk("vec_maddr", {8'd0, cap_maddr}, {8'd0, vecs[i].exp_maddr});
        chk("vec_wr", {31'd0, cap_wr}, {31'd0, vecs[i].we});
        chk("vec_wdata", {24'd0, cap_wdata}, {24'd0, vecs[i].wdata});
        chk("vec_rdata", {24'd0, cpu_rdata}, {24'd0, vecs[i].exp_rdata});
        chk("vec_stall", {31'd0, rdy_low}, 32'd1);
        chk("vec_stable", {31'd0, stable_ok}, 32'd1);
        if (pass == 0) begin
          chk("vec_en_cycles", en_hi_cnt, 1);
          chk("vec_latency", lat, vecs[i].exp_lat);
        end
      end
    end
    en_toggle = 1'b0;
    @(negedge clk);

    // mem_ready held low for 10 cycles after the request.
    busy_cycles = 1; resp_data = 8'h6E;
    do_access(1'b0, 16'hBEEF, 8'h00, 10);
    $display("[TB] hold read addr=BEEF mem_en_cycles=%0d rdata=%02h", en_hi_cnt, cpu_rdata);
    chk("hold_en_cycles", en_hi_cnt, 10);
    chk("hold_stable", {31'd0, stable_ok}, 32'd1);
    chk("hold_maddr", {8'd0, cap_maddr}, 32'h0005BEEF);
    chk("hold_rdata", {24'd0, cpu_rdata}, 32'h6E);

    // Reset while waiting in ISSUE.
    block_ready = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0033;
    repeat (3) @(negedge clk);
    chk("issue_mem_en", {31'd0, mem_en}, 32'd1);
    rst = 1'b1; cpu_req = 1'b0; block_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_issue_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_issue_rdy", {31'd0, cpu_rdy}, 32'd1);

    // Reset while waiting in WHIGH.
    busy_cycles = 8; resp_data = 8'hE7;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    repeat (5) @(negedge clk);
    chk("whigh_stalled", {31'd0, cpu_rdy}, 32'd0);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_whigh_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_whigh_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("rst_whigh_rdata", {24'd0, cpu_rdata}, 32'd0);
    got = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (cpu_ack) got = 1;
    end
    chk("rst_no_ack", {31'd0, got}, 32'd0);
    busy_cycles = 2; resp_data = 8'h3D;
    do_access(1'b0, 16'h0040, 8'h00, 0);
    $display("[TB] read after reset addr=0040 rdata=%02h", cpu_rdata);
    chk("post_rst_rdata", {24'd0, cpu_rdata}, 32'h3D);

`ifdef CPU_SRAM_BRIDGE_RCACHE_EN
    busy_cycles = 1; resp_data = 8'h77;
    do_access(1'b0, 16'h0200, 8'h00, 0);
    chk("cache_miss_mem_en", {31'd0, en_hi_cnt != 0}, 32'd1);
    resp_data = 8'h00;
    do_access(1'b0, 16'h0200, 8'h00, 0);
    $display("[TB] cache read 0200 rdata=%02h mem_en_cycles=%0d", cpu_rdata, en_hi_cnt);
    chk("cache_hit_mem_en", en_hi_cnt, 0);
    chk("cache_hit_rdy", {31'd0, rdy_low}, 32'd0);
    chk("cache_hit_rdata", {24'd0, cpu_rdata}, 32'h77);
    do_access(1'b1, 16'h0200, 8'h11, 0);
    chk("cache_wr_mem_en", {31'd0, en_hi_cnt != 0}, 32'd1);
    do_access(1'b0, 16'h0200, 8'h00, 0);
    $display("[TB] cache read after write 0200 rdata=%02h mem_en_cycles=%0d", cpu_rdata, en_hi_cnt);
    chk("cache_wt_mem_en", en_hi_cnt, 0);
    chk("cache_wt_rdata", {24'd0, cpu_rdata}, 32'h11);
`else
    busy_cycles = 1; resp_data = 8'h77;
    do_access(1'b0, 16'h0200, 8'h00, 0);
    resp_data = 8'h66;
    do_access(1'b0, 16'h0200, 8'h00, 0);
    $display("[TB] uncached repeat read 0200 rdata=%02h mem_en_cycles=%0d", cpu_rdata, en_hi_cnt);
    chk("nocache_mem_en", en_hi_cnt, 1);
    chk("nocache_rdata", {24'd0, cpu_rdata}, 32'h66);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
